tick_interval_meter: RTL
========================

Name: tick_interval_meter

Overview:
- Consumer end of the timebase tick interface. Measures elapsed time between a start event and a stop event by counting the one-clock timeout pulses emitted by the 1 ms / 100 ms timers.
- Presents the result with a valid/ack handshake to the game control logic, e.g. survival time or reaction time.
- Timebase is external: any one-cycle pulse source drives tick.

Parameters:
- COUNT_W, 16, width of the elapsed-tick counter and count_out. Must be a multiple of 4 when BCD mode is compiled in.

Ports:
- clock  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-low; clock clock
- tick  input  1  one-clock timebase pulse; each high cycle = one time unit
- start  input  1  one-clock pulse; begin or restart a measurement
- stop  input  1  one-clock pulse; end the measurement
- clear  input  1  synchronous abort; return to IDLE and zero all outputs
- result_ack  input  1  consumer accepts the current result
- running  output  1  high while in RUN
- result_valid  output  1  high in DONE until acknowledged
- overflow  output  1  sticky; counter saturated during this measurement
- count_out  output  COUNT_W  elapsed tick count, live in RUN, frozen otherwise

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; running=0, result_valid=0, overflow=0, count_out=0. Reset has priority over every input.
- States: IDLE, RUN, DONE. All outputs are registered; every transition takes effect on the next posedge.
- clear==1 (reset inactive): from any state, next cycle state=IDLE with all outputs 0. Priority: clear > start/stop/ack/tick.
- IDLE:
  - tick and stop are ignored; result_ack is ignored.
  - start==1 -> RUN; count_out<=0, overflow<=0, running<=1.
  - A tick in the same cycle as start is not counted.
- RUN:
  - tick==1 -> count_out<=count_out+1.
  - If count_out is already at the max code, hold it and set overflow<=1 (sticky until next start/clear/reset). No wrap-around.
  - stop==1 -> DONE; running<=0, result_valid<=1. A tick coincident with stop IS counted, so the frozen value includes it.
  - start==1 (restart) -> stays in RUN; count_out<=0, overflow<=0. Coincident tick is not counted.
  - start and stop in the same cycle: start wins (restart).
- DONE:
  - count_out and overflow are frozen; tick ignored.
  - result_ack==1 -> IDLE, result_valid<=0; count_out/overflow keep their values until the next start.
  - start is ignored while result_valid=1, so an unacknowledged result is never lost. start coincident with result_ack is also ignored; a new start must come at least one cycle after the ack.
- Latency: start->running = 1 clock; stop->result_valid = 1 clock; ack->result_valid low = 1 clock.
- Max code: binary build = 2^COUNT_W-1 (65535 at default); BCD build = all digits 9 (9999 at default).

Optional Feature:
- Macro: TICK_METER_BCD_EN.
- Defined:
  - count_out is a packed BCD counter of COUNT_W/4 digits, least significant digit in bits [3:0].
  - Each digit rolls 9->0 with carry into the next digit.
  - Saturates at all-9s and sets overflow, per the rules above.
  - Intended to drive 7-segment displays directly.
- Undefined: plain unsigned binary counter. No BCD logic is synthesized.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with tick toggling, then release -> all outputs 0; 5 ticks in IDLE leave count_out=0.
- Basic measure: start, then 7 tick pulses spaced 3 clocks apart, stop coincident with the 7th tick -> count_out=7, result_valid=1 one clock after stop, running=0; result_ack -> result_valid=0 next clock, count_out stays 7.
- Restart and priority:
  - In RUN at count 4, assert start -> count_out=0 next clock, overflow=0.
  - start+stop together -> remains RUN.
  - start in DONE before ack -> ignored, count_out unchanged.
- Saturation (COUNT_W=4, binary): 20 ticks -> count_out=15, overflow=1 from the 16th tick on; stop -> DONE with overflow=1; next start clears overflow.
- Clear mid-operation: in RUN at count 9 assert clear with a coincident tick -> next clock state IDLE, count_out=0, running=0, overflow=0.
- BCD build (TICK_METER_BCD_EN, COUNT_W=16):
  - 10 ticks -> count_out=16'h0010.
  - 9999 ticks -> 16'h9999; one more tick -> 16'h9999 with overflow=1.

Source files
------------

// File: rtl/tick_interval_meter.sv
// Start/stop elapsed-time meter counting timebase tick pulses, result on valid/ack.
// Define TICK_METER_BCD_EN to make count_out a packed BCD counter (COUNT_W/4 digits).
module tick_interval_meter #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               result_ack,
  output logic               running,
  output logic               result_valid,
  output logic               overflow,
  output logic [COUNT_W-1:0] count_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic               at_max;
  logic [COUNT_W-1:0] count_inc;

`ifdef TICK_METER_BCD_EN
  localparam int DIGITS = COUNT_W / 4;

  logic carry;

  // Ripple a +1 through the decimal digits; at_max means every digit is 9.
  always_comb begin
    count_inc = count_out;
    carry     = 1'b1;
    at_max    = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (count_out[4*d +: 4] != 4'd9) at_max = 1'b0;
      if (carry) begin
        if (count_out[4*d +: 4] == 4'd9) begin
          count_inc[4*d +: 4] = 4'd0;
        end else begin
          count_inc[4*d +: 4] = count_out[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end
`else
  localparam logic [COUNT_W-1:0] ONE = 1;

  assign count_inc = count_out + ONE;
  assign at_max    = &count_out;
`endif

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state        <= IDLE;
      running      <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      count_out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            running   <= 1'b1;
            count_out <= '0;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            count_out <= '0;
            overflow  <= 1'b0;
          end else begin
            // Saturate instead of wrapping; the stop-cycle tick still counts.
            if (tick) begin
              if (at_max) overflow  <= 1'b1;
              else        count_out <= count_inc;
            end
            if (stop) begin
              state        <= DONE;
              running      <= 1'b0;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          running      <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
